rst_seq: RTL and testbench
==========================

Name: rst_seq

Overview:
- Parametrised reset and clock-enable sequencer; successor to the fixed 14-bit cold-reset counter and divide-by-2 toggle.
- After a cold-start delay, waits for an upstream lock indication, then releases NCH reset domains one at a time with a programmable stagger.
- Re-arms on loss of lock or on a soft-reset request.
- Also generates a divided clock-enable pulse and a run-state heartbeat for LED drive. Sits at board top level, feeding eth_top and sibling subsystems.

Parameters:
- NCH, 4, number of staged reset outputs (≥1)
- COLD_W, 14, cold counter width; cold phase lasts 2^COLD_W cycles
- STAGE_DLY, 256, cycles between successive channel releases (≥1)
- DIV, 2, clk_en period in cycles (≥1)
- HB_W, 27, heartbeat counter width (≥2)

Ports:
- clk200, in, 1: single clock; all logic on rising edge.
- sys_rst_n, in, 1: asynchronous reset, active-low.
- locked, in, 1: asynchronous upstream lock/health flag (e.g. SFP clock alarm_b).
- soft_rst, in, 1: synchronous one-cycle request to re-sequence.
- rst_out, out, NCH: active-high per-domain resets; bit 0 is released first.
- rst_done, out, 1: high once all channels are released.
- clk_en, out, 1: one-cycle pulse every DIV cycles.
- heartbeat, out, 1: MSB of the heartbeat counter while in RUN, else 0.
- state_o, out, 2: current state (COLD=0, WAIT_LOCK=1, RELEASE=2, RUN=3).

Behaviour:
- Reset (sys_rst_n low, asynchronous), all registers cleared as follows:
  - state=COLD, rst_out all 1s, rst_done=0, clk_en=0, heartbeat=0.
  - All counters 0; locked synchroniser flops 0.
- locked passes through a 2-flop synchroniser (locked_s); 2-cycle latency.
- COLD:
  - cold_cnt increments each cycle.
  - When cold_cnt == 2^COLD_W-1, next state is WAIT_LOCK.
  - locked_s and soft_rst are ignored in this state.
- WAIT_LOCK:
  - While locked_s=1 and soft_rst=0, move to RELEASE with stage_cnt=0, idx=0.
  - Otherwise stay.
- RELEASE:
  - stage_cnt increments each cycle.
  - When stage_cnt == STAGE_DLY-1: clear rst_out[idx], set stage_cnt=0, idx=idx+1.
  - If idx == NCH-1 at that point: go to RUN and set rst_done=1 in the same edge.
  - Channel k deasserts (k+1)*STAGE_DLY cycles after entering RELEASE.
- RUN: hold all outputs. hb_cnt increments each cycle; heartbeat = hb_cnt[HB_W-1].
- Abort condition: in WAIT_LOCK, RELEASE or RUN, if locked_s=0 or soft_rst=1, then on the next edge:
  - rst_out set to all 1s, rst_done=0, state=WAIT_LOCK.
  - stage_cnt, idx and hb_cnt cleared.
  - Abort has priority over release progress, including on the same cycle a channel would release.
- clk_en:
  - Free-running mod-DIV counter, independent of state.
  - clk_en=1 when the counter == DIV-1. First pulse is on cycle DIV after reset release.
  - DIV=1: clk_en=1 every cycle after the first edge.
- Width rules:
  - stage_cnt width = clog2(STAGE_DLY) (minimum 1); idx width = clog2(NCH) (minimum 1).
  - Counters never wrap except hb_cnt (free wrap) and the DIV counter (modulo).
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
All scenarios use NCH=3, COLD_W=4, STAGE_DLY=4, DIV=2 unless stated.
1. Cold start, locked held 1 → state_o=0 for 16 cycles, then 1 until locked_s=1, then 2. rst_out steps 111→110→100→000 at 4-cycle intervals; rst_done=1 on the same edge as 000; state_o=3.
2. locked dropped to 0 for 1 cycle while in RUN → 2 cycles later rst_out=111, rst_done=0, state_o=1. After locked returns: full 12-cycle release again, heartbeat=0 throughout the re-release.
3. soft_rst pulsed during RELEASE after bit 0 cleared (rst_out=110) → next edge rst_out=111, state_o=1; then RELEASE restarts from channel 0. soft_rst pulsed during COLD → no effect and cold count unchanged.
4. Assert sys_rst_n low mid-RELEASE → outputs immediately (asynchronously) rst_out=111, rst_done=0, state_o=0, clk_en=0. Deassert → cold phase repeats for 16 cycles.
5. clk_en check: DIV=2 → pulse on every 2nd cycle. DIV=3 → pattern 0,0,1 repeating. DIV=1 → constant 1. Pattern is unaffected by abort events.
6. Boundary: NCH=1, STAGE_DLY=1 → rst_out clears and rst_done=1 one cycle after entering RELEASE. HB_W=2 in RUN → heartbeat toggles every 2 cycles.

Source files
------------

// File: rtl/rst_seq.sv
// rtl/rst_seq.sv - staged reset release sequencer with clock-enable and heartbeat
module rst_seq #(
    parameter int NCH       = 4,
    parameter int COLD_W    = 14,
    parameter int STAGE_DLY = 256,
    parameter int DIV       = 2,
    parameter int HB_W      = 27
) (
    input  logic             clk200,
    input  logic             sys_rst_n,
    input  logic             locked,
    input  logic             soft_rst,
    output logic [NCH-1:0]   rst_out,
    output logic             rst_done,
    output logic             clk_en,
    output logic             heartbeat,
    output logic [1:0]       state_o
);

    localparam int SW = (STAGE_DLY > 1) ? $clog2(STAGE_DLY) : 1;
    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [1:0] ST_COLD      = 2'd0;
    localparam logic [1:0] ST_WAIT_LOCK = 2'd1;
    localparam logic [1:0] ST_RELEASE   = 2'd2;
    localparam logic [1:0] ST_RUN       = 2'd3;

    localparam logic [SW-1:0] STAGE_LAST = SW'(STAGE_DLY - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NCH - 1);
    localparam logic [DW-1:0] DIV_LAST   = DW'(DIV - 1);

    logic              locked_meta_q;
    logic              locked_s_q;
    logic [1:0]        state_q,     state_d;
    logic [COLD_W-1:0] cold_cnt_q,  cold_cnt_d;
    logic [SW-1:0]     stage_cnt_q, stage_cnt_d;
    logic [IW-1:0]     idx_q,       idx_d;
    logic [NCH-1:0]    rst_out_q,   rst_out_d;
    logic              rst_done_q,  rst_done_d;
    logic [HB_W-1:0]   hb_cnt_q,    hb_cnt_d;
    logic              heartbeat_q, heartbeat_d;
    logic [DW-1:0]     div_cnt_q;
    logic              clk_en_q;
    logic              abort;

    // Bring the asynchronous lock flag into the clk200 domain
    always_ff @(posedge clk200 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            locked_meta_q <= 1'b0;
            locked_s_q    <= 1'b0;
        end else begin
            locked_meta_q <= locked;
            locked_s_q    <= locked_meta_q;
        end
    end

    // Loss of lock or a soft request re-arms everything once past the cold phase
    assign abort = !locked_s_q || soft_rst;

    // Sequencer next-state: cold wait, lock wait, staggered release, run
    always_comb begin
        state_d     = state_q;
        cold_cnt_d  = cold_cnt_q;
        stage_cnt_d = stage_cnt_q;
        idx_d       = idx_q;
        rst_out_d   = rst_out_q;
        rst_done_d  = rst_done_q;
        hb_cnt_d    = hb_cnt_q;

        if (state_q == ST_COLD) begin
            // Counter saturates at its terminal value; the cold phase runs only after a hard reset
            if (cold_cnt_q == '1) begin
                state_d = ST_WAIT_LOCK;
            end else begin
                cold_cnt_d = cold_cnt_q + COLD_W'(1);
            end
        end else if (abort) begin
            // Abort wins over any release progress on the same cycle
            state_d     = ST_WAIT_LOCK;
            stage_cnt_d = '0;
            idx_d       = '0;
            rst_out_d   = '1;
            rst_done_d  = 1'b0;
            hb_cnt_d    = '0;
        end else begin
            case (state_q)
                ST_WAIT_LOCK: begin
                    state_d     = ST_RELEASE;
                    stage_cnt_d = '0;
                    idx_d       = '0;
                end
                ST_RELEASE: begin
                    if (stage_cnt_q == STAGE_LAST) begin
                        stage_cnt_d = '0;
                        for (int k = 0; k < NCH; k++) begin
                            if (idx_q == IW'(k)) begin
                                rst_out_d[k] = 1'b0;
                            end
                        end
                        if (idx_q == IDX_LAST) begin
                            state_d    = ST_RUN;
                            rst_done_d = 1'b1;
                        end else begin
                            idx_d = idx_q + IW'(1);
                        end
                    end else begin
                        stage_cnt_d = stage_cnt_q + SW'(1);
                    end
                end
                ST_RUN: begin
                    hb_cnt_d = hb_cnt_q + HB_W'(1);
                end
                default: begin
                    state_d = ST_COLD;
                end
            endcase
        end
    end

    // Heartbeat is only visible while running so the LED stays dark during bring-up
    always_comb begin
        heartbeat_d = (state_d == ST_RUN) && hb_cnt_d[HB_W-1];
    end

    // Sequencer state registers
    always_ff @(posedge clk200 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= ST_COLD;
            cold_cnt_q  <= '0;
            stage_cnt_q <= '0;
            idx_q       <= '0;
            rst_out_q   <= '1;
            rst_done_q  <= 1'b0;
            hb_cnt_q    <= '0;
            heartbeat_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cold_cnt_q  <= cold_cnt_d;
            stage_cnt_q <= stage_cnt_d;
            idx_q       <= idx_d;
            rst_out_q   <= rst_out_d;
            rst_done_q  <= rst_done_d;
            hb_cnt_q    <= hb_cnt_d;
            heartbeat_q <= heartbeat_d;
        end
    end

    // Free-running divider; the pulse lands on edge DIV, 2*DIV, ... after reset release
    always_ff @(posedge clk200 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            div_cnt_q <= '0;
            clk_en_q  <= 1'b0;
        end else begin
            div_cnt_q <= (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DW'(1);
            clk_en_q  <= (div_cnt_q == DIV_LAST);
        end
    end

    assign rst_out   = rst_out_q;
    assign rst_done  = rst_done_q;
    assign clk_en    = clk_en_q;
    assign heartbeat = heartbeat_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_rst_seq.sv
// tb/tb_rst_seq.sv - self-checking bench for rst_seq over three parameter sets
module tb_rst_seq;

    logic clk200 = 1'b0;
    logic sys_rst_n = 1'b0;
    logic locked = 1'b1;
    logic soft_rst = 1'b0;

    always #5 clk200 = ~clk200;

    logic [2:0] ro_a;
    logic [0:0] ro_b;
    logic [1:0] ro_c;
    logic       done_w [3];
    logic       ce_w   [3];
    logic       hb_w   [3];
    logic [1:0] st_w   [3];
    logic [3:0] ro     [3];

    assign ro[0] = {1'b0, ro_a};
    assign ro[1] = {3'b000, ro_b};
    assign ro[2] = {2'b00, ro_c};

    rst_seq #(.NCH(3), .COLD_W(4), .STAGE_DLY(4), .DIV(2), .HB_W(3)) u_a (
        .clk200(clk200), .sys_rst_n(sys_rst_n), .locked(locked), .soft_rst(soft_rst),
        .rst_out(ro_a), .rst_done(done_w[0]), .clk_en(ce_w[0]), .heartbeat(hb_w[0]), .state_o(st_w[0]));

    rst_seq #(.NCH(1), .COLD_W(4), .STAGE_DLY(1), .DIV(3), .HB_W(2)) u_b (
        .clk200(clk200), .sys_rst_n(sys_rst_n), .locked(locked), .soft_rst(soft_rst),
        .rst_out(ro_b), .rst_done(done_w[1]), .clk_en(ce_w[1]), .heartbeat(hb_w[1]), .state_o(st_w[1]));

    rst_seq #(.NCH(2), .COLD_W(3), .STAGE_DLY(2), .DIV(1), .HB_W(5)) u_c (
        .clk200(clk200), .sys_rst_n(sys_rst_n), .locked(locked), .soft_rst(soft_rst),
        .rst_out(ro_c), .rst_done(done_w[2]), .clk_en(ce_w[2]), .heartbeat(hb_w[2]), .state_o(st_w[2]));

    int cnch [3] = '{3, 1, 2};
    int ccold[3] = '{4, 4, 3};
    int cstg [3] = '{4, 1, 2};
    int cdiv [3] = '{2, 3, 1};
    int chbw [3] = '{3, 2, 5};

    // Model: phase (0 cold,1 wait,2 release,3 run), time in release, run-time heartbeat count
    int mph [3];
    int mt  [3];
    int mhb [3];
    bit ml1 [3];
    bit ml2 [3];
    int medges;

    int n_vec = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d] got %0h expected %0h at %0t", nm, i, act, exp, $time);
        end
    endtask

    task automatic mreset();
        for (int i = 0; i < 3; i++) begin
            mph[i] = 0; mt[i] = 0; mhb[i] = 0; ml1[i] = 1'b0; ml2[i] = 1'b0;
        end
        medges = 0;
    endtask

    task automatic mstep();
        bit ab;
        for (int i = 0; i < 3; i++) begin
            ab = !ml2[i] || soft_rst;
            if (mph[i] == 0) begin
                if (medges == (1 << ccold[i]) - 1) mph[i] = 1;
            end else if (ab) begin
                mph[i] = 1; mt[i] = 0; mhb[i] = 0;
            end else if (mph[i] == 1) begin
                mph[i] = 2; mt[i] = 0;
            end else if (mph[i] == 2) begin
                mt[i]++;
                if (mt[i] == cnch[i] * cstg[i]) mph[i] = 3;
            end else begin
                mhb[i] = (mhb[i] + 1) % (1 << chbw[i]);
            end
            ml2[i] = ml1[i];
            ml1[i] = locked;
        end
        medges++;
    endtask

    function automatic logic [31:0] exp_rst(input int i);
        logic [31:0] v;
        v = '0;
        for (int k = 0; k < cnch[i]; k++) begin
            v[k] = !(mph[i] == 3 || (mph[i] == 2 && mt[i] >= (k + 1) * cstg[i]));
        end
        return v;
    endfunction

    always @(posedge clk200 or negedge sys_rst_n) begin
        if (!sys_rst_n) mreset();
        else            mstep();
    end

    // Per-cycle comparison of every instance against the model
    always @(negedge clk200) begin
        if (cmp_en) begin
            for (int i = 0; i < 3; i++) begin
                chk("rst_out",   i, 32'(ro[i]),     exp_rst(i));
                chk("rst_done",  i, 32'(done_w[i]), 32'(mph[i] == 3));
                chk("state_o",   i, 32'(st_w[i]),   32'(mph[i]));
                chk("clk_en",    i, 32'(ce_w[i]),   32'(medges > 0 && (medges % cdiv[i]) == 0));
                chk("heartbeat", i, 32'(hb_w[i]),
                    32'(mph[i] == 3 && (((mhb[i] >> (chbw[i] - 1)) & 1) == 1)));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk200);
        #1;
    endtask

    initial begin
        mreset();
        cmp_en = 1'b1;
        tick(3);
        chk("lit_reset_rst_out", 0, 32'(ro_a), 32'h7);
        chk("lit_reset_state", 0, 32'(st_w[0]), 32'h0);
        sys_rst_n = 1'b1;

        // First bring-up, with a soft request during cold that must be ignored
        tick(5);  soft_rst = 1'b1;
        tick(1);  soft_rst = 1'b0;
        tick(9);  chk("lit_cold_edge15", 0, 32'(st_w[0]), 32'h0);
        tick(1);  chk("lit_wait_edge16", 0, 32'(st_w[0]), 32'h1);
        tick(1);  chk("lit_rel_edge17", 0, 32'(st_w[0]), 32'h2);
                  chk("lit_rel_rst_out", 0, 32'(ro_a), 32'h7);
                  chk("lit_div3_edge17", 1, 32'(ce_w[1]), 32'h0);
        tick(1);  chk("lit_b_run", 1, 32'(st_w[1]), 32'h3);
                  chk("lit_b_rst_out", 1, 32'(ro_b), 32'h0);
                  chk("lit_div3_edge18", 1, 32'(ce_w[1]), 32'h1);
        tick(2);  chk("lit_b_heartbeat", 1, 32'(hb_w[1]), 32'h1);
        tick(1);  chk("lit_ch0_edge21", 0, 32'(ro_a), 32'h6);
        tick(8);  chk("lit_all_edge29", 0, 32'(ro_a), 32'h0);
                  chk("lit_done_edge29", 0, 32'(done_w[0]), 32'h1);
                  chk("lit_run_edge29", 0, 32'(st_w[0]), 32'h3);

        // One-cycle loss of lock while running
        tick(11); locked = 1'b0;
        tick(1);  locked = 1'b1;
        tick(2);  chk("lit_unlock_state", 0, 32'(st_w[0]), 32'h1);
                  chk("lit_unlock_rst_out", 0, 32'(ro_a), 32'h7);
                  chk("lit_unlock_done", 0, 32'(done_w[0]), 32'h0);
        tick(1);  chk("lit_rerel_state", 0, 32'(st_w[0]), 32'h2);
        tick(4);  chk("lit_rerel_ch0", 0, 32'(ro_a), 32'h6);

        // Soft reset after channel 0 released
        tick(1);  soft_rst = 1'b1;
        tick(1);  soft_rst = 1'b0;
                  chk("lit_soft_rst_out", 0, 32'(ro_a), 32'h7);
                  chk("lit_soft_state", 0, 32'(st_w[0]), 32'h1);
        tick(5);  chk("lit_soft_rerel_ch0", 0, 32'(ro_a), 32'h6);

        // Asynchronous reset in the middle of a release
        tick(1);
        #2 sys_rst_n = 1'b0;
        #1;
        chk("lit_async_rst_out", 0, 32'(ro_a), 32'h7);
        chk("lit_async_done", 0, 32'(done_w[0]), 32'h0);
        chk("lit_async_state", 0, 32'(st_w[0]), 32'h0);
        chk("lit_async_clk_en", 2, 32'(ce_w[2]), 32'h0);
        tick(2);
        sys_rst_n = 1'b1;

        // Second bring-up; soft request lands on the exact release edge of channel 0
        tick(15); chk("lit_cold2_edge15", 0, 32'(st_w[0]), 32'h0);
        tick(1);  chk("lit_wait2_edge16", 0, 32'(st_w[0]), 32'h1);
        tick(4);  soft_rst = 1'b1;
        tick(1);  soft_rst = 1'b0;
                  chk("lit_prio_rst_out", 0, 32'(ro_a), 32'h7);
                  chk("lit_prio_state", 0, 32'(st_w[0]), 32'h1);
        tick(13); chk("lit_run2_state", 0, 32'(st_w[0]), 32'h3);
        tick(10);

        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
